// File: rtl/ft_run_monitor.sv
// Run supervisor for the lockstep multi-core SoC. It checks the cores' instruction
// addresses against each other, detects program completion through the memory-mapped
// flag word, and enforces a run-length timeout. Every output is registered.
module ft_run_monitor #(
  parameter int unsigned NUM_CORES      = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned MISMATCH_TOL   = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        clear_i,
  input  logic [NUM_CORES-1:0]        core_en_i,
  input  logic [NUM_CORES*ADDR_W-1:0] instr_addr_i,
  input  logic [DATA_W-1:0]           mem_flag_i,
  input  logic [DATA_W-1:0]           mem_result_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        timeout_o,
  output logic                        diverged_o,
  output logic                        irq_o,
  output logic [DATA_W-1:0]           result_o,
  output logic [CNT_W-1:0]            cycles_o,
  output logic [NUM_CORES-1:0]        diverge_mask_o
);

  // The mismatch counter only has to reach MISMATCH_TOL, because the run ends there.
  localparam int unsigned MisW  = $clog2(MISMATCH_TOL + 1);
  localparam int unsigned MisW1 = MisW + 1;
  localparam int unsigned CntW1 = CNT_W + 1;

  localparam logic [MisW:0]  TolVal = MisW1'(MISMATCH_TOL);
  localparam logic [MisW:0]  MisOne = MisW1'(1);
  localparam logic [CNT_W:0] ToVal  = CntW1'(TIMEOUT_CYCLES);
  localparam logic [CNT_W:0] CntOne = CntW1'(1);

  typedef enum logic [2:0] {StIdle, StRun, StDone, StTimeout, StDiverged} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]     cycles_q, cycles_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [MisW-1:0]      mis_cnt_q, mis_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 diverged_q, diverged_d;
  logic                 irq_q, irq_d;

  logic [ADDR_W-1:0]    ref_addr;
  logic                 ref_found;
  logic [NUM_CORES-1:0] cmp_mask;
  logic                 mismatch;
  logic [MisW:0]        mis_inc;
  logic [CNT_W:0]       cyc_inc;
  logic [CNT_W-1:0]     cycles_sat;
  logic                 flag_hit;
  logic                 div_hit;
  logic                 to_hit;

  // Lockstep compare against the lowest-index enabled core. A lone enabled core
  // matches itself, so fewer than two enabled cores never reports a mismatch.
  always_comb begin
    ref_found = 1'b0;
    ref_addr  = '0;
    cmp_mask  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_en_i[i] && !ref_found) begin
        ref_found = 1'b1;
        ref_addr  = instr_addr_i[i*ADDR_W +: ADDR_W];
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      cmp_mask[i] = core_en_i[i] && (instr_addr_i[i*ADDR_W +: ADDR_W] != ref_addr);
    end
    mismatch   = |cmp_mask;
    mis_inc    = {1'b0, mis_cnt_q} + MisOne;
    cyc_inc    = {1'b0, cycles_q} + CntOne;
    cycles_sat = cyc_inc[CNT_W] ? {CNT_W{1'b1}} : cyc_inc[CNT_W-1:0];
    flag_hit   = (mem_flag_i != '0);
    div_hit    = mismatch && (mis_inc == TolVal);
    to_hit     = (TIMEOUT_CYCLES != 0) && (cyc_inc == ToVal);
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. RUN exits are prioritised: completion, then divergence, then timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (start_i) state_d = StRun;
      StRun: begin
        if (flag_hit)     state_d = StDone;
        else if (div_hit) state_d = StDiverged;
        else if (to_hit)  state_d = StTimeout;
      end
      StDone, StTimeout, StDiverged: if (clear_i) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Next values for the registered outputs. Captured values are held outside RUN.
  always_comb begin
    cycles_d   = cycles_q;
    result_d   = result_q;
    mask_d     = mask_q;
    mis_cnt_d  = mis_cnt_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          cycles_d  = '0;
          result_d  = '0;
          mask_d    = '0;
          mis_cnt_d = '0;
        end
      end
      StRun: begin
        // The exit cycle still counts, so the cycle count advances unconditionally.
        cycles_d  = cycles_sat;
        mis_cnt_d = mismatch ? mis_inc[MisW-1:0] : '0;
        if (flag_hit)     result_d = mem_result_i;
        else if (div_hit) mask_d   = cmp_mask;
      end
      default: ;
    endcase
    busy_d     = (state_d == StRun);
    done_d     = (state_d == StDone);
    timeout_d  = (state_d == StTimeout);
    diverged_d = (state_d == StDiverged);
    irq_d      = (state_q == StRun) && (state_d != StRun);
  end

  // Output and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q   <= '0;
      result_q   <= '0;
      mask_q     <= '0;
      mis_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      diverged_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      cycles_q   <= cycles_d;
      result_q   <= result_d;
      mask_q     <= mask_d;
      mis_cnt_q  <= mis_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      diverged_q <= diverged_d;
      irq_q      <= irq_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign timeout_o      = timeout_q;
  assign diverged_o     = diverged_q;
  assign irq_o          = irq_q;
  assign result_o       = result_q;
  assign cycles_o       = cycles_q;
  assign diverge_mask_o = mask_q;

endmodule

// File: tb/tb_ft_run_monitor.sv
// Scoreboard bench for ft_run_monitor. A whole run of per-cycle stimulus is built up
// front, and a reference model replays it to predict the run's outcome. The prediction
// is queued, and a monitor pops it and compares it on every irq pulse.
module tb_ft_run_monitor;

  localparam int NC  = 3;
  localparam int AW  = 8;
  localparam int TO  = 100;
  localparam int TOL = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i, clear_i;
  logic [NC-1:0] core_en_i;
  logic [NC*AW-1:0] instr_addr_i;
  logic [31:0]   mem_flag_i, mem_result_i;
  logic          busy_o, done_o, timeout_o, diverged_o, irq_o;
  logic [31:0]   result_o, cycles_o;
  logic [NC-1:0] diverge_mask_o;

  ft_run_monitor #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(32), .CNT_W(32),
    .TIMEOUT_CYCLES(TO), .MISMATCH_TOL(TOL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .clear_i(clear_i),
    .core_en_i(core_en_i), .instr_addr_i(instr_addr_i), .mem_flag_i(mem_flag_i),
    .mem_result_i(mem_result_i), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .diverged_o(diverged_o), .irq_o(irq_o), .result_o(result_o), .cycles_o(cycles_o),
    .diverge_mask_o(diverge_mask_o)
  );

  always #5 clk = ~clk;

  // kind: 0 = done, 1 = timeout, 2 = diverged
  typedef struct packed {
    logic [1:0]    kind;
    logic [31:0]   res;
    logic [31:0]   cyc;
    logic [NC-1:0] mask;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Stimulus for RUN cycles 1..TO
  logic [NC-1:0] st_en   [0:TO];
  logic [AW-1:0] st_a    [0:TO][0:NC-1];
  logic [31:0]   st_flag [0:TO];
  logic [31:0]   st_res  [0:TO];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] flags_of(input logic [1:0] kind);
    // {busy, done, timeout, diverged}
    case (kind)
      2'd0:    return 4'b0100;
      2'd1:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  // Reference model: walks the run cycle by cycle and applies the exit rules directly.
  function automatic exp_t model();
    exp_t          e;
    int            streak;
    logic [AW-1:0] refa;
    bit            found;
    logic [NC-1:0] m;
    e = '0;
    streak = 0;
    for (int c = 1; c <= TO; c++) begin
      found = 0;
      refa  = '0;
      for (int k = 0; k < NC; k++)
        if (st_en[c][k] && !found) begin found = 1; refa = st_a[c][k]; end
      for (int k = 0; k < NC; k++) m[k] = st_en[c][k] && (st_a[c][k] != refa);
      if (st_flag[c] != 0) begin
        e.kind = 2'd0; e.res = st_res[c]; e.cyc = 32'(c); e.mask = '0;
        return e;
      end
      streak = (m != 0) ? streak + 1 : 0;
      if (streak == TOL) begin
        e.kind = 2'd2; e.res = '0; e.cyc = 32'(c); e.mask = m;
        return e;
      end
      if (c == TO) begin
        e.kind = 2'd1; e.res = '0; e.cyc = 32'(c); e.mask = '0;
        return e;
      end
    end
    return e;
  endfunction

  task automatic fill_quiet(input logic [NC-1:0] en);
    logic [AW-1:0] base;
    for (int c = 0; c <= TO; c++) begin
      base = AW'($urandom);
      st_en[c] = en;
      for (int k = 0; k < NC; k++) st_a[c][k] = base;
      st_flag[c] = '0;
      st_res[c]  = $urandom;
    end
  endtask

  task automatic fill_random(input int p_done, input int p_mis);
    logic [AW-1:0] base;
    logic [NC-1:0] en;
    en = NC'($urandom);
    for (int c = 0; c <= TO; c++) begin
      if ($urandom_range(0, 9) == 0) en = NC'($urandom);
      base = AW'($urandom);
      st_en[c] = en;
      for (int k = 0; k < NC; k++)
        st_a[c][k] = (int'($urandom_range(0, 99)) < p_mis) ?
                     base ^ AW'($urandom_range(1, 255)) : base;
      st_flag[c] = (int'($urandom_range(0, 99)) < p_done) ? ($urandom | 32'h1) : 32'h0;
      st_res[c]  = $urandom;
    end
  endtask

  task automatic apply(input int c);
    core_en_i    = st_en[c];
    instr_addr_i = {st_a[c][2], st_a[c][1], st_a[c][0]};
    mem_flag_i   = st_flag[c];
    mem_result_i = st_res[c];
  endtask

  // Starts a run and drives it through the exit cycle; inputs change #1 after posedge.
  task automatic run_seq(input exp_t e);
    sb_q.push_back(e);
    start_i = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= int'(e.cyc); c++) begin
      apply(c);
      start_i = ($urandom_range(0, 3) == 0);
      clear_i = ($urandom_range(0, 3) == 0);
      if (c == 1) check("busy_first_cycle", 64'(busy_o), 64'd1);
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    clear_i = 1'b0;
    mem_flag_i = '0;
  endtask

  // Terminal hold: irq is single-cycle, start is ignored, clear returns to IDLE
  // with the captured values still visible.
  task automatic post_run(input exp_t e);
    @(posedge clk); #1;
    check("irq_single_pulse", 64'(irq_o), 64'd0);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("terminal_hold_flags", 64'({busy_o, done_o, timeout_o, diverged_o}),
          64'(flags_of(e.kind)));
    check("terminal_hold_cycles", 64'(cycles_o), 64'(e.cyc));
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    check("idle_flags", 64'({busy_o, done_o, timeout_o, diverged_o, irq_o}), 64'd0);
    check("idle_keeps_cycles", 64'(cycles_o), 64'(e.cyc));
    check("idle_keeps_result", 64'(result_o), 64'(e.res));
    @(posedge clk); #1;
  endtask

  task automatic do_run(input exp_t e);
    run_seq(e);
    post_run(e);
  endtask

  // Scoreboard monitor: every irq pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (irq_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_irq", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("exit_flags", 64'({busy_o, done_o, timeout_o, diverged_o}),
              64'(flags_of(mon_e.kind)));
        check("exit_result", 64'(result_o), 64'(mon_e.res));
        check("exit_cycles", 64'(cycles_o), 64'(mon_e.cyc));
        check("exit_mask", 64'(diverge_mask_o), 64'(mon_e.mask));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; start_i = 1'b0; clear_i = 1'b0; core_en_i = '0;
    instr_addr_i = '0; mem_flag_i = '0; mem_result_i = '0;
    #2;
    check("reset_outputs_async",
          64'({busy_o, done_o, timeout_o, diverged_o, irq_o, result_o, diverge_mask_o}), 64'd0);
    check("reset_cycles", 64'(cycles_o), 64'd0);
    start_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ignores_start", 64'(busy_o), 64'd0);
    start_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Completion on the 10th RUN cycle
    fill_quiet(3'b011);
    st_flag[10] = 32'd1; st_res[10] = 32'd55;
    e = model();
    check("model_completion_cycles", 64'(e.cyc), 64'd10);
    do_run(e);

    // Timeout at 100 cycles
    fill_quiet(3'b111);
    do_run(model());

    // 2-cycle mismatch then match, later a 3-cycle mismatch on core1
    fill_quiet(3'b011);
    st_a[5][1] = st_a[5][0] ^ 8'h01;
    st_a[6][1] = st_a[6][0] ^ 8'h01;
    for (int c = 20; c <= 22; c++) st_a[c][1] = st_a[c][0] ^ 8'h80;
    do_run(model());

    // Completion, divergence and timeout all reached on cycle 100
    fill_quiet(3'b011);
    for (int c = 98; c <= 100; c++) st_a[c][1] = st_a[c][0] ^ 8'h10;
    st_flag[100] = 32'h4; st_res[100] = 32'hCAFE_F00D;
    do_run(model());

    // core0 disabled with garbage; core2 departs from the core1 reference
    fill_quiet(3'b110);
    for (int c = 0; c <= TO; c++) st_a[c][0] = st_a[c][1] ^ 8'h5A;
    for (int c = 30; c <= 32; c++) st_a[c][2] = st_a[c][1] ^ 8'h03;
    do_run(model());

    // Reset in the middle of a run
    fill_quiet(3'b111);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 1; c <= 19; c++) begin apply(c); @(posedge clk); #1; end
    check("midrun_cycles", 64'(cycles_o), 64'd19);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs",
          64'({busy_o, done_o, timeout_o, diverged_o, irq_o, result_o, diverge_mask_o}), 64'd0);
    check("midrun_reset_cycles", 64'(cycles_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill_quiet(3'b111);
    st_flag[1] = 32'h8000_0000; st_res[1] = $urandom;
    do_run(model());

    // Randomised runs
    for (int r = 0; r < 30; r++) begin
      fill_random(int'($urandom_range(0, 6)), int'($urandom_range(0, 40)));
      do_run(model());
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ft_run_monitor.md
Name: ft_run_monitor

Overview:
- Synthesizable run supervisor for the multi-core fault-tolerant SoC.
- Watches the instruction addresses of NUM_CORES cores for lockstep divergence.
- Detects program completion through the memory-mapped flag word, captures the result word and cycle count, and enforces a cycle timeout.
- Sits beside the cores on the SoC top level and drives an interrupt/status interface for the host or supervisor.

Parameters:
- NUM_CORES, 2, number of monitored cores (≥2).
- ADDR_W, 32, width of each instruction address.
- DATA_W, 32, width of the flag and result words.
- CNT_W, 32, width of the cycle counter.
- TIMEOUT_CYCLES, 100, run-length limit in cycles; 0 disables the timeout.
- MISMATCH_TOL, 1, consecutive mismatching cycles that declare divergence (≥1).

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  starts a run; honoured only in IDLE.
- clear_i  in  1  returns any terminal state to IDLE.
- core_en_i  in  NUM_CORES  per-core compare enable.
- instr_addr_i  in  NUM_CORES*ADDR_W  core i address in bits [i*ADDR_W +: ADDR_W].
- mem_flag_i  in  DATA_W  completion flag word; nonzero means done.
- mem_result_i  in  DATA_W  result word.
- busy_o  out  1  high in RUN.
- done_o  out  1  high in DONE.
- timeout_o  out  1  high in TIMEOUT.
- diverged_o  out  1  high in DIVERGED.
- irq_o  out  1  one-cycle pulse on entry to any terminal state.
- result_o  out  DATA_W  mem_result_i captured at completion.
- cycles_o  out  CNT_W  cycles spent in RUN.
- diverge_mask_o  out  NUM_CORES  cores that disagreed with the reference core.

Behaviour:
- Reset (async, rst_ni=0):
  - State = IDLE.
  - All outputs = 0; mismatch counter = 0.
- States: IDLE, RUN, DONE, TIMEOUT, DIVERGED. All outputs are registered.
- IDLE:
  - start_i=1 → RUN next cycle.
  - On that transition: cycles_o, result_o, diverge_mask_o and the mismatch counter clear.
- RUN, each cycle:
  - cycles_o increments and saturates at all-ones.
  - Reference core = lowest-index core with core_en_i set.
  - mismatch = some enabled core's address differs from the reference address.
  - With fewer than 2 cores enabled, mismatch = 0.
  - Mismatch counter increments on a mismatch cycle and resets to 0 on any matching cycle.
- RUN exit conditions, evaluated on the same edge, priority high to low:
  1. mem_flag_i≠0 → DONE; result_o ← mem_result_i.
  2. Mismatch counter+1 == MISMATCH_TOL on a mismatch cycle → DIVERGED; diverge_mask_o ← per-core (enabled AND addr≠ref).
  3. TIMEOUT_CYCLES≠0 and cycles_o+1 == TIMEOUT_CYCLES → TIMEOUT.
- Cycle counting on exit:
  - cycles_o counts the exit cycle.
  - A run that completes on its first RUN cycle reports cycles_o=1.
- irq_o is asserted in the same cycle the terminal-state flag first rises, for exactly 1 cycle.
- Terminal states (DONE/TIMEOUT/DIVERGED):
  - Held, with all captured outputs frozen, until clear_i=1 → IDLE next cycle.
  - Captured values remain readable in IDLE until the next start.
- In RUN or IDLE, clear_i is ignored. start_i is ignored outside IDLE.
- core_en_i may change mid-run and takes effect on the same cycle.
- Reset mid-run: immediate IDLE; all outputs 0; no irq.

Test Plan:
1. Completion. NUM_CORES=2, equal addresses. start_i, then mem_flag_i=1 and mem_result_i=55 asserted on the 10th RUN cycle → done_o=1, result_o=55, cycles_o=10, one irq_o pulse, busy_o=0.
2. Timeout. TIMEOUT_CYCLES=100, flag held at 0 → timeout_o=1 with cycles_o=100. Then clear_i → IDLE, timeout_o=0, cycles_o still 100.
3. Divergence. MISMATCH_TOL=3, core1 address differs for 3 consecutive cycles → diverged_o=1, diverge_mask_o=2'b10. A 2-cycle mismatch followed by a match must not trigger divergence.
4. Simultaneous events. Flag≠0 on the same cycle that timeout and divergence are both reached → DONE only; diverge_mask_o=0, timeout_o=0.
5. Enables. NUM_CORES=3, core_en_i=3'b110, core0 address garbage → no divergence (reference is core1). Core2 then differs → diverge_mask_o=3'b100.
6. Reset mid-run. rst_ni pulsed low asynchronously at cycle 20 of RUN → all outputs 0 immediately. After reset release, start_i is accepted normally and cycles_o restarts from 1.
